// File: rtl/sparse_pkg.sv
// Shared defaults and types for the sparse encoder.
package sparse_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = $clog2(LANES);
  localparam int unsigned NNZ_W  = $clog2(LANES + 1);

  typedef enum logic [0:0] {
    IDLE,
    EMIT
  } state_e;

endpackage

// File: rtl/sparse_compressor_lsb_find.sv
// Lowest-set-bit priority encoder; also reused by the bitmap decoder side.
module lsb_find #(
  parameter int unsigned LANES = sparse_pkg::LANES,
  parameter int unsigned IDX_W = sparse_pkg::IDX_W
) (
  input  logic [LANES-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_compressor.sv
// Streaming sparse encoder: dense vector in, bitmap plus (value, lane) beats out.
// Optional feature macro SPARSE_ENC_NNZ_EN adds the out_nnz popcount port.
module sparse_compressor #(
  parameter int unsigned LANES  = sparse_pkg::LANES,
  parameter int unsigned DATA_W = sparse_pkg::DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic [LANES-1:0]          comp,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(LANES)-1:0]  out_idx,
  output logic                      out_last,
  output logic                      out_empty
`ifdef SPARSE_ENC_NNZ_EN
  ,
  output logic [$clog2(LANES+1)-1:0] out_nnz
`endif
);

  import sparse_pkg::*;

  localparam int unsigned IW = $clog2(LANES);

  state_e                  state_q, state_d;
  logic [LANES-1:0]        rem_q, rem_d;
  logic [LANES-1:0]        comp_q, comp_d;
  logic [LANES*DATA_W-1:0] data_q, data_d;
  logic [LANES-1:0]        mask;
  logic [DATA_W-1:0]       lanes [LANES];
  logic [IW-1:0]           lsb_idx;
  logic                    lsb_any;
  logic                    single;
  logic                    fire;
  logic                    accept;

  // Nonzero mask of the incoming vector and unpacked view of the latched one.
  always_comb begin
    mask = '0;
    for (int k = 0; k < LANES; k++) begin
      mask[k]  = |in_data[k*DATA_W +: DATA_W];
      lanes[k] = data_q[k*DATA_W +: DATA_W];
    end
  end

  lsb_find #(
    .LANES (LANES),
    .IDX_W (IW)
  ) u_lsb_find (
    .vec (rem_q),
    .idx (lsb_idx),
    .any (lsb_any)
  );

  // Outputs decode from registered state only; rem is zero outside EMIT.
  always_comb begin
    single    = (rem_q & (rem_q - LANES'(1))) == '0;
    out_valid = (state_q == EMIT);
    out_idx   = lsb_idx;
    out_data  = (out_valid && lsb_any) ? lanes[lsb_idx] : '0;
    out_empty = out_valid && (comp_q == '0);
    out_last  = out_valid && (!lsb_any || single);
    comp      = comp_q;
    fire      = out_valid && out_ready;
    in_ready  = !out_valid || (fire && out_last);
    accept    = in_valid && in_ready;
  end

  // Next state: retire the current beat, then a new vector overrides on acceptance.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    comp_d  = comp_q;
    data_d  = data_q;
    if (fire) begin
      rem_d = rem_q & ~(LANES'(1) << lsb_idx);
      if (out_last) state_d = IDLE;
    end
    if (accept) begin
      state_d = EMIT;
      rem_d   = mask;
      comp_d  = mask;
      data_d  = in_data;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      comp_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      comp_q  <= comp_d;
      data_q  <= data_d;
    end
  end

`ifdef SPARSE_ENC_NNZ_EN
  logic [$clog2(LANES+1)-1:0] nnz_q, nnz_d;

  // Popcount of the accepted mask, held for the whole vector.
  always_comb begin
    nnz_d = nnz_q;
    if (accept) begin
      nnz_d = '0;
      for (int k = 0; k < LANES; k++) begin
        nnz_d = nnz_d + $bits(nnz_d)'(mask[k]);
      end
    end
  end

  // Nonzero-count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) nnz_q <= '0;
    else      nnz_q <= nnz_d;
  end

  assign out_nnz = nnz_q;
`endif

endmodule

// File: tb/tb_sparse_compressor.sv
// Self-checking bench for sparse_compressor with a queue-based beat model.
module tb_sparse_compressor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  comp;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        out_empty;
`ifdef SPARSE_ENC_NNZ_EN
  logic [3:0]  out_nnz;
`endif

  sparse_compressor #(
    .LANES  (8),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .comp      (comp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_empty (out_empty)
`ifdef SPARSE_ENC_NNZ_EN
    ,
    .out_nnz   (out_nnz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] data;
    bit         last;
    bit         empty;
  } beat_t;

  beat_t       q[$];
  logic [7:0]  m_comp;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          rand_rdy = 1'b0;

  // Beats actually handshaken, for literal checks of directed cases.
  logic [2:0]  log_idx[$];
  logic [7:0]  log_data[$];
  bit          log_last[$];
  bit          log_empty[$];
  int          log_cyc[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void clear_log();
    log_idx.delete();
    log_data.delete();
    log_last.delete();
    log_empty.delete();
    log_cyc.delete();
  endfunction

  // Expand a dense vector into its beat list: nonzero lanes in ascending order.
  function automatic void push_vector(input logic [63:0] v);
    beat_t b;
    int    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (v[k*8 +: 8] != 8'd0) begin
        b.idx = 3'(k); b.data = v[k*8 +: 8]; b.last = 1'b0; b.empty = 1'b0;
        q.push_back(b);
        n++;
      end
    end
    if (n == 0) begin
      b.idx = 3'd0; b.data = 8'd0; b.last = 1'b1; b.empty = 1'b1;
      q.push_back(b);
    end else begin
      q[q.size()-1].last = 1'b1;
    end
  endfunction

  function automatic logic [7:0] mask_of(input logic [63:0] v);
    logic [7:0] m;
    for (int k = 0; k < 8; k++) m[k] = (v[k*8 +: 8] != 8'd0);
    return m;
  endfunction

  function automatic logic [3:0] popcnt(input logic [7:0] m);
    logic [3:0] c = 4'd0;
    for (int k = 0; k < 8; k++) c = c + 4'(m[k]);
    return c;
  endfunction

  // Compare process: checks every cycle on the falling edge.
  always @(negedge clk) begin
    bit exp_ready;
    cyc++;
    if (!rst) begin
      q.delete();
      m_comp = 8'd0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_comp", 32'(comp), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end else begin
      exp_ready = (q.size() == 0) ? 1'b1 : (out_ready && q[0].last);
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("comp", 32'(comp), 32'(m_comp));
`ifdef SPARSE_ENC_NNZ_EN
      chk("out_nnz", 32'(out_nnz), 32'(popcnt(m_comp)));
`endif
      if (q.size() != 0) begin
        chk("out_idx", 32'(out_idx), 32'(q[0].idx));
        chk("out_data", 32'(out_data), 32'(q[0].data));
        chk("out_last", 32'(out_last), 32'(q[0].last));
        chk("out_empty", 32'(out_empty), 32'(q[0].empty));
        if (out_ready) begin
          log_idx.push_back(out_idx);
          log_data.push_back(out_data);
          log_last.push_back(out_last);
          log_empty.push_back(out_empty);
          log_cyc.push_back(cyc);
          void'(q.pop_front());
        end
      end
      if (in_valid && exp_ready) begin
        push_vector(in_data);
        m_comp = mask_of(in_data);
      end
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [63:0] v);
    in_data  = v;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    for (int t = 0; t < lim; t++) begin
      if (q.size() == 0 && !out_valid) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    logic [63:0] v;
    logic [3:0]  pat;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_idx", 32'(out_idx), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_out_empty", 32'(out_empty), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Lane order: {5,0,0,-3,7,1,2,9}.
    clear_log();
    send({8'd9, 8'd2, 8'd1, 8'd7, 8'hFD, 8'd0, 8'd0, 8'd5});
    chk("lit_comp", 32'(comp), 32'hF9);
`ifdef SPARSE_ENC_NNZ_EN
    chk("lit_nnz6", 32'(out_nnz), 32'd6);
`endif
    drain(50);
    chk("lit_order_n", 32'(log_idx.size()), 32'd6);
    if (log_idx.size() == 6) begin
      chk("lit_idx0", 32'(log_idx[0]), 32'd0);
      chk("lit_data0", 32'(log_data[0]), 32'd5);
      chk("lit_idx1", 32'(log_idx[1]), 32'd3);
      chk("lit_data1", 32'(log_data[1]), 32'hFD);
      chk("lit_idx2", 32'(log_idx[2]), 32'd4);
      chk("lit_idx5", 32'(log_idx[5]), 32'd7);
      chk("lit_data5", 32'(log_data[5]), 32'd9);
      chk("lit_last4", 32'(log_last[4]), 32'd0);
      chk("lit_last5", 32'(log_last[5]), 32'd1);
      chk("lit_span", 32'(log_cyc[5] - log_cyc[0]), 32'd5);
    end

    // All-zero vector.
    clear_log();
    send(64'd0);
    chk("lit_zero_comp", 32'(comp), 32'd0);
`ifdef SPARSE_ENC_NNZ_EN
    chk("lit_nnz0", 32'(out_nnz), 32'd0);
`endif
    drain(20);
    chk("lit_zero_n", 32'(log_idx.size()), 32'd1);
    if (log_idx.size() == 1) begin
      chk("lit_zero_empty", 32'(log_empty[0]), 32'd1);
      chk("lit_zero_last", 32'(log_last[0]), 32'd1);
      chk("lit_zero_data", 32'(log_data[0]), 32'd0);
    end

    // Back-to-back: A lanes 0,7 then B lane 1.
    clear_log();
    send({8'h77, 48'd0, 8'h11});
    send({48'd0, 8'h22, 8'd0});
    drain(20);
    chk("lit_b2b_n", 32'(log_idx.size()), 32'd3);
    if (log_idx.size() == 3) begin
      chk("lit_b2b_idx0", 32'(log_idx[0]), 32'd0);
      chk("lit_b2b_idx1", 32'(log_idx[1]), 32'd7);
      chk("lit_b2b_idx2", 32'(log_idx[2]), 32'd1);
      chk("lit_b2b_gap", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
    end

    // Backpressure with out_ready pattern 1,0,0,1 on mask 01101111.
    clear_log();
    pat = 4'b1001;
    send({8'd0, 8'h16, 8'h15, 8'd0, 8'h13, 8'h12, 8'h11, 8'h10});
    for (int c = 0; c < 60; c++) begin
      if (q.size() == 0 && !out_valid) break;
      out_ready = pat[c % 4];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain(10);
    chk("lit_bp_n", 32'(log_idx.size()), 32'd6);
    if (log_idx.size() == 6) begin
      chk("lit_bp_idx3", 32'(log_idx[3]), 32'd3);
      chk("lit_bp_idx4", 32'(log_idx[4]), 32'd5);
      chk("lit_bp_idx5", 32'(log_idx[5]), 32'd6);
    end

    // Reset after 2 of 6 beats.
    clear_log();
    send({8'd9, 8'd2, 8'd1, 8'd7, 8'hFD, 8'd0, 8'd0, 8'd5});
    @(posedge clk); @(posedge clk); #1;
    chk("lit_rst_beats", 32'(log_idx.size()), 32'd2);
    rst = 1'b0;
    #1;
    chk("lit_rst_valid", 32'(out_valid), 32'd0);
    chk("lit_rst_comp", 32'(comp), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("lit_rst_ready", 32'(in_ready), 32'd1);
    clear_log();
    send({8'd0, 8'd0, 8'h33, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    drain(20);
    chk("lit_post_rst_n", 32'(log_idx.size()), 32'd1);
    if (log_idx.size() == 1) chk("lit_post_rst_idx", 32'(log_idx[0]), 32'd5);

    // Randomized traffic with random backpressure.
    @(posedge clk); #1;
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      v = '0;
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 1) == 1) v[k*8 +: 8] = 8'($urandom_range(1, 255));
      end
      if (n % 17 == 0) v = '0;
      send(v);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
